ttt_sweep_scheduler: RTL and testbench

Sequencer and arbiter for the shared single-port neuron-state memory of the tick-tock-tokens core. It turns tick and tock start requests into full sweeps over every neuron index. It also arbitrates the same memory port between those sweeps and host configuration accesses. It sits between the top-level control decode and the neuron-state RAM/update datapath, whose port mux is driven by `mem_host`.

---
 rtl/ttt_sweep_scheduler_if.sv | 29 ++
 rtl/ttt_sweep_scheduler.sv | 104 ++++++++++
 tb/tb_ttt_sweep_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ttt_sweep_scheduler_if.sv
// ttt_sweep_scheduler_if: request/grant and memory-port signals of the sweep scheduler
interface ttt_sweep_scheduler_if #(
   parameter int IDX_W = 3
);
   logic             start_tick;
   logic             start_tock;
   logic             host_req;
   logic [IDX_W-1:0] host_addr;
   logic             clr_overrun;
   logic             mem_en;
   logic [IDX_W-1:0] mem_addr;
   logic             mem_host;
   logic [1:0]       phase;
   logic             host_gnt;
   logic             tick_done;
   logic             tock_done;
   logic             busy;
   logic             overrun;

   modport master (
      output start_tick, start_tock, host_req, host_addr, clr_overrun,
      input  mem_en, mem_addr, mem_host, phase, host_gnt, tick_done, tock_done, busy, overrun
   );

   modport slave (
      input  start_tick, start_tock, host_req, host_addr, clr_overrun,
      output mem_en, mem_addr, mem_host, phase, host_gnt, tick_done, tock_done, busy, overrun
   );
endinterface

// File: rtl/ttt_sweep_scheduler.sv
// ttt_sweep_scheduler: tick/tock sweep sequencer and host arbiter for the neuron-state memory port
// Define TTT_SCHED_HOST_INTERLEAVE_EN to let host accesses slip in between sweep slots.
module ttt_sweep_scheduler #(
   parameter int NUM_NEURONS = 8,
   parameter int IDX_W       = 3
) (
   input logic                  clk,
   input logic                  rst,
   ttt_sweep_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, TICK, TOCK, HOST} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

   state_t           r_state, w_state_n, r_ret, w_ret_n, w_sweep;
   logic [IDX_W-1:0] r_idx, w_idx_n, w_addr_n, r_mem_addr;
   logic             r_pend_tick, r_pend_tock, w_pt, w_po, w_tick_done_n, w_tock_done_n;
   logic             r_mem_en, r_mem_host, r_host_gnt, r_tick_done, r_tock_done, r_busy, r_overrun;
   logic [1:0]       r_phase;

   // Next state: a done cycle and a host cycle both hand over straight to any queued sweep
   always_comb begin
      w_pt          = r_pend_tick | bus.start_tick;
      w_po          = r_pend_tock | bus.start_tock;
      w_sweep       = w_pt ? TICK : (w_po ? TOCK : IDLE);
      w_state_n     = r_state;
      w_ret_n       = IDLE;
      w_idx_n       = r_idx;
      w_tick_done_n = 1'b0;
      w_tock_done_n = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_n = (w_sweep == IDLE && bus.host_req) ? HOST : w_sweep;
            w_idx_n   = '0;
         end
         TICK, TOCK: begin
            if (r_idx == LAST) begin
               w_tick_done_n = (r_state == TICK);
               w_tock_done_n = (r_state == TOCK);
               w_state_n     = w_sweep;
               w_idx_n       = '0;
            end
`ifdef TTT_SCHED_HOST_INTERLEAVE_EN
            else if (bus.host_req) begin
               w_state_n = HOST;
               w_ret_n   = r_state;
            end
`endif
            else w_idx_n = r_idx + 1'b1;
         end
         default: begin
            w_state_n = (r_ret == IDLE) ? w_sweep : r_ret;
            w_idx_n   = (r_ret == IDLE) ? '0 : r_idx + 1'b1;
         end
      endcase
      w_addr_n = (w_state_n == HOST) ? bus.host_addr : w_idx_n;
   end

   // State, pending flags and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ret       <= IDLE;
         r_idx       <= '0;
         r_pend_tick <= 1'b0;
         r_pend_tock <= 1'b0;
         r_overrun   <= 1'b0;
         r_mem_en    <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_host  <= 1'b0;
         r_host_gnt  <= 1'b0;
         r_phase     <= 2'd0;
         r_mem_addr  <= '0;
         r_tick_done <= 1'b0;
         r_tock_done <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_ret       <= w_ret_n;
         r_idx       <= w_idx_n;
         r_pend_tick <= w_pt & ~(w_state_n == TICK && w_idx_n == '0);
         r_pend_tock <= w_po & ~(w_state_n == TOCK && w_idx_n == '0);
         r_overrun   <= (r_overrun & ~bus.clr_overrun) | (bus.start_tick & r_pend_tick) |
                        (bus.start_tock & r_pend_tock);
         r_mem_en    <= (w_state_n != IDLE);
         r_busy      <= (w_state_n != IDLE);
         r_mem_host  <= (w_state_n == HOST);
         r_host_gnt  <= (w_state_n == HOST);
         r_phase     <= (w_state_n == HOST) ? 2'd0 : w_state_n;
         r_mem_addr  <= w_addr_n;
         r_tick_done <= w_tick_done_n;
         r_tock_done <= w_tock_done_n;
      end
   end

   assign bus.mem_en    = r_mem_en;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_host  = r_mem_host;
   assign bus.phase     = r_phase;
   assign bus.host_gnt  = r_host_gnt;
   assign bus.tick_done = r_tick_done;
   assign bus.tock_done = r_tock_done;
   assign bus.busy      = r_busy;
   assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_ttt_sweep_scheduler.sv
// tb_ttt_sweep_scheduler: directed checks of sweep timing, queueing, overrun, host access and reset
module tb_ttt_sweep_scheduler;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   ttt_sweep_scheduler_if #(.IDX_W(3)) bus ();

   ttt_sweep_scheduler #(.NUM_NEURONS(8), .IDX_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_port(input string tag, input logic en, input int addr, input logic host,
                              input int ph);
      check({tag, ".mem_en"}, 32'(bus.mem_en), 32'(en));
      check({tag, ".mem_addr"}, 32'(bus.mem_addr), addr);
      check({tag, ".mem_host"}, 32'(bus.mem_host), 32'(host));
      check({tag, ".phase"}, 32'(bus.phase), ph);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b0;
      bus.start_tick  = 1'b0;
      bus.start_tock  = 1'b0;
      bus.host_req    = 1'b0;
      bus.host_addr   = 3'd0;
      bus.clr_overrun = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      expect_port("reset", 1'b0, 0, 1'b0, 0);
      check("reset.host_gnt", 32'(bus.host_gnt), 0);
      check("reset.tick_done", 32'(bus.tick_done), 0);
      check("reset.tock_done", 32'(bus.tock_done), 0);
      check("reset.busy", 32'(bus.busy), 0);
      check("reset.overrun", 32'(bus.overrun), 0);
      rst = 1'b0;
      cyc();
      check("idle.busy", 32'(bus.busy), 0);

      // single tick sweep
      bus.start_tick = 1'b1;
      cyc();
      bus.start_tick = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_port("tick.slot", 1'b1, i, 1'b0, 1);
         cyc();
      end
      check("tick.done", 32'(bus.tick_done), 1);
      check("tick.busy_done", 32'(bus.busy), 0);
      check("tick.en_done", 32'(bus.mem_en), 0);
      cyc();
      check("tick.done_pulse", 32'(bus.tick_done), 0);

      // simultaneous tick and tock: back to back
      bus.start_tick = 1'b1;
      bus.start_tock = 1'b1;
      cyc();
      bus.start_tick = 1'b0;
      bus.start_tock = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_port("both.tick", 1'b1, i, 1'b0, 1);
         cyc();
      end
      check("both.tick_done", 32'(bus.tick_done), 1);
      expect_port("both.tock0", 1'b1, 0, 1'b0, 2);
      for (int i = 1; i < 8; i++) begin
         cyc();
         expect_port("both.tock", 1'b1, i, 1'b0, 2);
      end
      cyc();
      check("both.tock_done", 32'(bus.tock_done), 1);
      check("both.busy_end", 32'(bus.busy), 0);
      cyc();

      // overrun: two tock requests during a tick sweep
      bus.start_tick = 1'b1;
      cyc();
      bus.start_tick = 1'b0;
      bus.start_tock = 1'b1;
      cyc();
      check("ovr.first", 32'(bus.overrun), 0);
      cyc();
      bus.start_tock = 1'b0;
      check("ovr.second", 32'(bus.overrun), 1);
      repeat (6) cyc();
      check("ovr.tick_done", 32'(bus.tick_done), 1);
      expect_port("ovr.tock0", 1'b1, 0, 1'b0, 2);
      repeat (8) cyc();
      check("ovr.tock_done", 32'(bus.tock_done), 1);
      check("ovr.busy_end", 32'(bus.busy), 0);
      cyc();
      check("ovr.one_tock", 32'(bus.mem_en), 0);
      check("ovr.sticky", 32'(bus.overrun), 1);
      bus.clr_overrun = 1'b1;
      cyc();
      bus.clr_overrun = 1'b0;
      check("ovr.cleared", 32'(bus.overrun), 0);

      // host request during a tick sweep
      bus.host_addr  = 3'd5;
      bus.start_tick = 1'b1;
      cyc();
      bus.start_tick = 1'b0;
      cyc();
      bus.host_req = 1'b1;
      check("host.slot1", 32'(bus.mem_addr), 1);
`ifdef TTT_SCHED_HOST_INTERLEAVE_EN
      cyc();
      check("host.gnt", 32'(bus.host_gnt), 1);
      expect_port("host.access", 1'b1, 5, 1'b1, 0);
      bus.host_req = 1'b0;
      for (int i = 2; i < 8; i++) begin
         cyc();
         expect_port("host.resume", 1'b1, i, 1'b0, 1);
      end
      cyc();
      check("host.tick_done", 32'(bus.tick_done), 1);
`else
      for (int i = 2; i < 8; i++) begin
         cyc();
         expect_port("host.sweep", 1'b1, i, 1'b0, 1);
         check("host.no_gnt", 32'(bus.host_gnt), 0);
      end
      cyc();
      check("host.tick_done", 32'(bus.tick_done), 1);
      check("host.done_gnt", 32'(bus.host_gnt), 0);
      check("host.done_en", 32'(bus.mem_en), 0);
      cyc();
      check("host.gnt", 32'(bus.host_gnt), 1);
      expect_port("host.access", 1'b1, 5, 1'b1, 0);
      bus.host_req = 1'b0;
`endif
      cyc();
      check("host.gnt_pulse", 32'(bus.host_gnt), 0);
      check("host.busy_end", 32'(bus.busy), 0);

      // asynchronous reset mid-sweep drops outputs and pending work
      bus.start_tick = 1'b1;
      cyc();
      bus.start_tick = 1'b0;
      bus.start_tock = 1'b1;
      cyc();
      bus.start_tock = 1'b0;
      cyc();
      cyc();
      check("rst.idx3", 32'(bus.mem_addr), 3);
      #1 rst = 1'b1;
      #1;
      expect_port("rst.async", 1'b0, 0, 1'b0, 0);
      check("rst.busy", 32'(bus.busy), 0);
      check("rst.tick_done", 32'(bus.tick_done), 0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("rst.no_done", 32'(bus.tick_done | bus.tock_done), 0);
         check("rst.no_sweep", 32'(bus.mem_en), 0);
      end
      bus.start_tock = 1'b1;
      cyc();
      bus.start_tock = 1'b0;
      expect_port("rst.fresh", 1'b1, 0, 1'b0, 2);
      repeat (8) cyc();
      check("rst.tock_done", 32'(bus.tock_done), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
